// File: rtl/alu_multicycle.sv
// 16-bit-class ALU with valid/ready input handshake, iterative shift-add multiply
// and restoring divide; results and flags are registered and pulse OUT_VALID once.
module alu_multicycle #(
  parameter int WIDTH = 16,
  parameter int WFUN  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WFUN-1:0]  ALU_FUN,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] ALU_OUT_HI,
  output logic [7:0]       Flags_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [WFUN-1:0] OP_ADD  = 'd0;
  localparam logic [WFUN-1:0] OP_SUB  = 'd1;
  localparam logic [WFUN-1:0] OP_MUL  = 'd2;
  localparam logic [WFUN-1:0] OP_DIV  = 'd3;
  localparam logic [WFUN-1:0] OP_AND  = 'd4;
  localparam logic [WFUN-1:0] OP_OR   = 'd5;
  localparam logic [WFUN-1:0] OP_NAND = 'd6;
  localparam logic [WFUN-1:0] OP_NOR  = 'd7;
  localparam logic [WFUN-1:0] OP_XOR  = 'd8;
  localparam logic [WFUN-1:0] OP_XNOR = 'd9;
  localparam logic [WFUN-1:0] OP_EQ   = 'd10;
  localparam logic [WFUN-1:0] OP_GT   = 'd11;
  localparam logic [WFUN-1:0] OP_LT   = 'd12;
  localparam logic [WFUN-1:0] OP_SHR  = 'd13;
  localparam logic [WFUN-1:0] OP_SHL  = 'd14;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WFUN-1:0]    op_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem, quo;
  logic [CW-1:0]      cnt;
  logic               accept, last, load;

  assign accept = IN_VALID && IN_READY;
  assign last   = (cnt == CW'(WIDTH - 1));

  // Shift-add step: {hi, multiplier} accumulator, add multiplicand on LSB, shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_step;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
  assign acc_step = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step: remainder < divisor, so the shifted value fits in WIDTH+1 bits.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_step, quo_step;
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ge    = ~div_diff[WIDTH];
  assign rem_step  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign quo_step  = {quo[WIDTH-2:0], div_ge};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (ALU_FUN == OP_MUL)                   next_state = ST_MUL;
          else if (ALU_FUN == OP_DIV && B != '0)   next_state = ST_DIV;
          else                                     next_state = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: if (last) next_state = ST_DONE;
      ST_DONE:        next_state = ST_IDLE;
      default:        next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
      acc  <= '0;
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= ALU_FUN;
            acc  <= {{WIDTH{1'b0}}, B};
            rem  <= '0;
            quo  <= A;
            cnt  <= '0;
          end
        end
        ST_MUL: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        ST_DIV: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  logic [WFUN-1:0]  op;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             carry, ovf, dz;
  logic             cls_arith, cls_logic, cls_cmp, cls_shift;
  logic [7:0]       flags_d;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  // Results are loaded on the edge that enters DONE, so single-cycle ops decode
  // the live inputs in IDLE while MUL/DIV take the final iteration step.
  always_comb begin
    res_lo = '0;
    res_hi = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    dz     = 1'b0;
    op     = (state == ST_IDLE) ? ALU_FUN : op_q;
    case (state)
      ST_MUL: begin
        res_lo = acc_step[WIDTH-1:0];
        res_hi = acc_step[2*WIDTH-1:WIDTH];
        ovf    = |acc_step[2*WIDTH-1:WIDTH];
      end
      ST_DIV: begin
        res_lo = quo_step;
        res_hi = rem_step;
      end
      default: begin
        case (ALU_FUN)
          OP_ADD: begin
            res_lo = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
            ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
          end
          OP_SUB: begin
            res_lo = diff[WIDTH-1:0];
            carry  = diff[WIDTH];
            ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
          end
          OP_DIV: begin
            res_lo = '1;
            res_hi = A;
            dz     = 1'b1;
          end
          OP_AND:  res_lo = A & B;
          OP_OR:   res_lo = A | B;
          OP_NAND: res_lo = ~(A & B);
          OP_NOR:  res_lo = ~(A | B);
          OP_XOR:  res_lo = A ^ B;
          OP_XNOR: res_lo = ~(A ^ B);
          OP_EQ:   res_lo = (A == B) ? WIDTH'(1) : '0;
          OP_GT:   res_lo = (A > B)  ? WIDTH'(2) : '0;
          OP_LT:   res_lo = (A < B)  ? WIDTH'(3) : '0;
          OP_SHR: begin
            res_lo = {1'b0, A[WIDTH-1:1]};
            carry  = A[0];
          end
          OP_SHL: begin
            res_lo = {A[WIDTH-2:0], 1'b0};
            carry  = A[WIDTH-1];
          end
          default: ;
        endcase
      end
    endcase
    cls_arith = (op <= OP_DIV);
    cls_logic = (op >= OP_AND) && (op <= OP_XNOR);
    cls_cmp   = (op >= OP_EQ) && (op <= OP_LT);
    cls_shift = (op == OP_SHR) || (op == OP_SHL);
    flags_d   = {dz, ovf, (res_lo == '0), carry, cls_shift, cls_cmp, cls_logic, cls_arith};
    load      = (next_state == ST_DONE) && (state != ST_DONE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_OUT    <= '0;
      ALU_OUT_HI <= '0;
      Flags_out  <= '0;
      OUT_VALID  <= 1'b0;
      IN_READY   <= 1'b1;
    end else begin
      OUT_VALID <= load;
      IN_READY  <= (next_state == ST_IDLE);
      if (load) begin
        ALU_OUT    <= res_lo;
        ALU_OUT_HI <= res_hi;
        Flags_out  <= flags_d;
      end
    end
  end

endmodule
